// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [4:0]        IF_ID_Rs_i,
  input  logic [4:0]        IF_ID_Rt_i,
  input  logic [4:0]        IF_ID_Rd_i,
  input  logic [DATA_W-1:0] RD1_i,
  input  logic [DATA_W-1:0] RD2_i,
  input  logic [DATA_W-1:0] SignExt_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  output logic [4:0]        ID_EX_Rs_o,
  output logic [4:0]        ID_EX_Rt_o,
  output logic [4:0]        ID_EX_Rd_o,
  output logic [DATA_W-1:0] RD1_o,
  output logic [DATA_W-1:0] RD2_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              RegDst_o,
  output logic [1:0]        ALUOp_o,
  output logic              valid_o,
  output logic              PCWrite_o,
  output logic              IF_ID_Write_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Handshake: valid_i marks a real instruction in ID; it advances into EX on
  // an edge where stall_i=0 and no flush/load-use bubble is taken. valid_o
  // marks a real instruction in EX. stall_i freezes everything, counter too.
  logic              r_valid;
  logic [4:0]        r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;
  logic              r_regwrite, r_memtoreg, r_memread, r_memwrite, r_alusrc, r_regdst;
  logic [1:0]        r_aluop;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_cnt_max;

  // A load in EX whose destination is read by the instruction in ID; $0 never counts.
  assign w_load_use = r_valid & r_memread & (r_rt != 5'd0) & valid_i & ~flush_i &
                      ((r_rt == IF_ID_Rs_i) | (r_rt == IF_ID_Rt_i));
  assign w_bubble   = flush_i | w_load_use | ~valid_i;
  assign w_cnt_max  = &r_bubble_cnt;

  assign PCWrite_o     = ~stall_i & ~w_load_use;
  assign IF_ID_Write_o = ~stall_i & ~w_load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alusrc     <= 1'b0;
      r_regdst     <= 1'b0;
      r_aluop      <= '0;
      r_bubble_cnt <= '0;
    end else if (!stall_i) begin
      if (w_bubble) begin
        // Clearing MemRead here is what ends a load-use bubble after one cycle.
        r_valid    <= 1'b0;
        r_rs       <= '0;
        r_rt       <= '0;
        r_rd       <= '0;
        r_rd1      <= '0;
        r_rd2      <= '0;
        r_imm      <= '0;
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_alusrc   <= 1'b0;
        r_regdst   <= 1'b0;
        r_aluop    <= '0;
      end else begin
        r_valid    <= 1'b1;
        r_rs       <= IF_ID_Rs_i;
        r_rt       <= IF_ID_Rt_i;
        r_rd       <= IF_ID_Rd_i;
        r_rd1      <= RD1_i;
        r_rd2      <= RD2_i;
        r_imm      <= SignExt_i;
        r_regwrite <= RegWrite_i;
        r_memtoreg <= MemToReg_i;
        r_memread  <= MemRead_i;
        r_memwrite <= MemWrite_i;
        r_alusrc   <= ALUSrc_i;
        r_regdst   <= RegDst_i;
        r_aluop    <= ALUOp_i;
      end
      if (w_load_use && !w_cnt_max) begin
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign valid_o      = r_valid;
  assign ID_EX_Rs_o   = r_rs;
  assign ID_EX_Rt_o   = r_rt;
  assign ID_EX_Rd_o   = r_rd;
  assign RD1_o        = r_rd1;
  assign RD2_o        = r_rd2;
  assign Imm_o        = r_imm;
  assign RegWrite_o   = r_regwrite;
  assign MemToReg_o   = r_memtoreg;
  assign MemRead_o    = r_memread;
  assign MemWrite_o   = r_memwrite;
  assign ALUSrc_o     = r_alusrc;
  assign RegDst_o     = r_regdst;
  assign ALUOp_o      = r_aluop;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
